// File: rtl/autofire_ctrl_if.sv
//------------------------------------------------------------------------------
// autofire_ctrl_if : run enable, raw speed keys and sequencer outputs
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface autofire_ctrl_if;
  logic enable;
  logic key_up;
  logic key_down;
  logic count_en;
  logic af_increment;
  logic af_decriment;
  logic key_active;

  modport master (
    output enable, key_up, key_down,
    input  count_en, af_increment, af_decriment, key_active
  );

  modport slave (
    input  enable, key_up, key_down,
    output count_en, af_increment, af_decriment, key_active
  );
endinterface

`default_nettype wire

// File: rtl/autofire_ctrl.sv
//------------------------------------------------------------------------------
// autofire_ctrl : tick timebase, key debounce and auto-repeat pulse sequencer
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module autofire_ctrl #(
  parameter int PRESCALE       = 21477,
  parameter int DEBOUNCE_TICKS = 8,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input wire logic        clk21m,
  input wire logic        reset_n,
  autofire_ctrl_if.slave  af_bus
);

  localparam logic [15:0] c_pre_last = 16'(PRESCALE - 1);
  localparam logic [7:0]  c_db_last  = 8'(DEBOUNCE_TICKS - 1);
  localparam logic [15:0] c_delay    = 16'(REPEAT_DELAY);
  localparam logic [15:0] c_rate     = 16'(REPEAT_RATE);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [1:0]  r_s1;
  logic [1:0]  r_s2;
  logic [15:0] r_pre;
  logic        w_tick;
  logic [1:0]  w_db;
  logic [1:0]  r_state;
  logic [1:0]  r_latch;
  logic [15:0] r_rc;
  logic        r_count_en;
  logic        r_inc;
  logic        r_dec;

  logic [1:0]  w_code;
  logic        w_valid;
  logic        w_fire;
  logic [1:0]  w_state_nxt;
  logic [1:0]  w_latch_nxt;
  logic [15:0] w_rc_nxt;

  // Synchronisers keep running while disabled so the key level is fresh on resume
  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 2'b00;
      r_s2 <= 2'b00;
    end else begin
      r_s1 <= {af_bus.key_down, af_bus.key_up};
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= 16'd0;
    end else if (af_bus.enable) begin
      r_pre <= (r_pre == c_pre_last) ? 16'd0 : r_pre + 16'd1;
    end
  end

  assign w_tick = af_bus.enable && (r_pre == c_pre_last);

  // Bit 0 is the up key, bit 1 the down key
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic       r_db;
    logic [7:0] r_dc;

    always_ff @(posedge clk21m or negedge reset_n) begin
      if (!reset_n) begin
        r_db <= 1'b0;
        r_dc <= 8'd0;
      end else if (w_tick) begin
        if (r_s2[i] != r_db) begin
          if (r_dc == c_db_last) begin
            r_db <= r_s2[i];
            r_dc <= 8'd0;
          end else begin
            r_dc <= r_dc + 8'd1;
          end
        end else begin
          r_dc <= 8'd0;
        end
      end
    end

    assign w_db[i] = r_db;
  end

  assign w_code  = w_db;
  assign w_valid = (w_code == 2'b01) || (w_code == 2'b10);

  always_comb begin
    w_state_nxt = r_state;
    w_latch_nxt = r_latch;
    w_rc_nxt    = r_rc;
    w_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          w_latch_nxt = w_code;
          w_fire      = 1'b1;
          w_rc_nxt    = c_delay;
          w_state_nxt = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        // Any change of code, including to the other key, drops back to IDLE first
        if (w_code != r_latch) begin
          w_state_nxt = S_IDLE;
        end else if (r_rc == 16'd1) begin
          w_fire      = 1'b1;
          w_rc_nxt    = c_rate;
          w_state_nxt = S_REPEAT;
        end else begin
          w_rc_nxt = r_rc - 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_latch <= 2'b00;
      r_rc    <= 16'd0;
    end else if (w_tick) begin
      r_state <= w_state_nxt;
      r_latch <= w_latch_nxt;
      r_rc    <= w_rc_nxt;
    end
  end

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      r_count_en <= 1'b0;
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
    end else begin
      r_count_en <= w_tick;
      r_inc      <= w_tick && w_fire && (w_code == 2'b01);
      r_dec      <= w_tick && w_fire && (w_code == 2'b10);
    end
  end

  // Strobes are masked by enable so nothing leaks out in the cycle enable drops
  assign af_bus.count_en     = r_count_en && af_bus.enable;
  assign af_bus.af_increment = r_inc && af_bus.enable;
  assign af_bus.af_decriment = r_dec && af_bus.enable;
  assign af_bus.key_active   = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_autofire_ctrl.sv
//------------------------------------------------------------------------------
// tb_autofire_ctrl : scoreboard bench with a tick-level reference model
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_autofire_ctrl;

    localparam int P  = 8;
    localparam int DB = 3;
    localparam int RD = 5;
    localparam int RR = 2;
    localparam int C_TIMEOUT_NS = 5000000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    autofire_ctrl_if af_if ();

    autofire_ctrl #(
        .PRESCALE       (P),
        .DEBOUNCE_TICKS (DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk21m  (clk),
        .reset_n (reset_n),
        .af_bus  (af_if)
    );

    always #5 clk = ~clk;

    logic [3:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit done  = 1'b0;

    // Reference model: counts enabled cycles and ticks, schedules pulses by absolute tick number
    int enc, tnum, next_fire, held;
    int mis[2];
    bit db[2], hs1[2], hs2[2];
    bit active, rce, rinc, rdec;
    bit cur_en, cur_ku, cur_kd, cur_rn;

    function void model_clear();
        enc = 0; tnum = 0; next_fire = 0; held = 0; active = 0;
        rce = 0; rinc = 0; rdec = 0;
        for (int k = 0; k < 2; k++) begin
            mis[k] = 0; db[k] = 0; hs1[k] = 0; hs2[k] = 0;
        end
    endfunction

    function void model_edge();
        bit tick;
        int code;
        bit raw[2];
        if (!cur_rn) begin
            model_clear();
            return;
        end
        tick = cur_en && ((enc % P) == P - 1);
        if (cur_en) enc++;
        rce = tick; rinc = 0; rdec = 0;
        if (tick) begin
            code = (db[1] ? 2 : 0) + (db[0] ? 1 : 0);
            if (!active) begin
                if (code == 1 || code == 2) begin
                    rinc = (code == 1); rdec = (code == 2);
                    active = 1; held = code; next_fire = tnum + RD;
                end
            end else if (code != held) begin
                active = 0;
            end else if (tnum == next_fire) begin
                rinc = (code == 1); rdec = (code == 2);
                next_fire = tnum + RR;
            end
            for (int k = 0; k < 2; k++) begin
                if (hs2[k] != db[k]) begin
                    mis[k]++;
                    if (mis[k] == DB) begin
                        db[k] = hs2[k];
                        mis[k] = 0;
                    end
                end else begin
                    mis[k] = 0;
                end
            end
            tnum++;
        end
        raw[0] = cur_ku; raw[1] = cur_kd;
        for (int k = 0; k < 2; k++) begin
            hs2[k] = hs1[k];
            hs1[k] = raw[k];
        end
    endfunction

    task automatic step(input bit en, input bit ku, input bit kd, input bit rn);
        logic [3:0] got;
        @(posedge clk);
        #1;
        model_edge();
        cur_en = en; cur_ku = ku; cur_kd = kd; cur_rn = rn;
        af_if.enable = en; af_if.key_up = ku; af_if.key_down = kd;
        reset_n = rn;
        if (!rn) begin
            model_clear();
            #1;
            got = {af_if.count_en, af_if.af_increment, af_if.af_decriment, af_if.key_active};
            n_cmp++;
            if (got !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset state cyc=%0d ce/inc/dec/act got=%b expected=0000", cyc, got);
            end
        end
        exp_q.push_back({rce && cur_en, rinc && cur_en, rdec && cur_en, active});
        cyc++;
    endtask

    task automatic hold(input int n, input bit en, input bit ku, input bit kd);
        for (int i = 0; i < n; i++) step(en, ku, kd, 1'b1);
    endtask

    // Monitor: one expected output vector per cycle, checked mid-cycle
    always @(negedge clk) begin
        logic [3:0] e, got;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {af_if.count_en, af_if.af_increment, af_if.af_decriment, af_if.key_active};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d ce/inc/dec/act got=%b expected=%b", cyc, got, e);
            end
        end
    end

    // Watchdog: the stimulus must complete within a bounded time
    initial begin
        #(C_TIMEOUT_NS);
        if (!done) begin
            n_bad++;
            $display("FAIL timeout: stimulus did not finish within %0d ns (cyc=%0d)", C_TIMEOUT_NS, cyc);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        af_if.enable = 1'b0;
        af_if.key_up = 1'b0;
        af_if.key_down = 1'b0;
        cur_en = 0; cur_ku = 0; cur_kd = 0; cur_rn = 0;
        model_clear();

        // Reset, then idle for 100 ticks
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        hold(100 * P, 1'b1, 1'b0, 1'b0);

        // Glitch shorter than the debounce window
        hold(2 * P, 1'b1, 1'b1, 1'b0);
        hold(10 * P, 1'b1, 1'b0, 1'b0);

        // Hold up, then hold down
        hold(20 * P, 1'b1, 1'b1, 1'b0);
        hold(10 * P, 1'b1, 1'b0, 1'b0);
        hold(20 * P, 1'b1, 1'b0, 1'b1);
        hold(10 * P, 1'b1, 1'b0, 1'b0);

        // Both keys, then release up
        hold(10 * P, 1'b1, 1'b1, 1'b1);
        hold(12 * P, 1'b1, 1'b0, 1'b1);
        hold(10 * P, 1'b1, 1'b0, 1'b0);

        // Enable drop and asynchronous reset during REPEAT
        hold(13 * P + 3, 1'b1, 1'b1, 1'b0);
        hold(20, 1'b0, 1'b1, 1'b0);
        hold(8 * P, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        hold(12 * P, 1'b1, 1'b1, 1'b0);
        hold(10 * P, 1'b1, 1'b0, 1'b0);

        // Randomised key patterns with occasional enable drops and resets
        for (int s = 0; s < 250; s++) begin
            int len;
            bit en, ku, kd;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 160) : $urandom_range(1, 40);
            en  = ($urandom_range(0, 7) != 0);
            ku  = ($urandom_range(0, 2) == 0);
            kd  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 59) == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(en, ku, kd, 1'b0);
            end
            hold(len, en, ku, kd);
        end
        hold(10 * P, 1'b1, 1'b0, 1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
